mac_acc_array: RTL and testbench

MAC_ACC_ARRAY -- requirements
Module: mac_acc_array

---
 rtl/mac_acc_array.sv | 126 ++++++++++++
 tb/tb_mac_acc_array.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_array.sv
// Multi-lane signed multiply-free accumulator array with batch control.
// Each lane sums a batch of beats, optionally saturating on overflow.
module mac_acc_array #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int COUNT      = 8,
   parameter int TERMS_W    = 16,
   parameter int SATURATE   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [TERMS_W-1:0]          num_terms,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH*COUNT-1:0] A_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_WIDTH*COUNT-1:0]  A_out,
   output logic [COUNT-1:0]            overflow,
   output logic                        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_e;

   localparam logic [ACC_WIDTH-1:0] MAX_V =
      {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] MIN_V =
      {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_e state_q, state_d;

   logic [COUNT-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [COUNT-1:0]                 ovf_q, ovf_d;
   logic [TERMS_W-1:0]               cnt_q, cnt_d;
   logic [TERMS_W-1:0]               terms_q, terms_d;
   logic [TERMS_W-1:0]               cnt_inc;

   logic [COUNT-1:0][DATA_WIDTH-1:0] a_lanes;
   logic [COUNT-1:0][ACC_WIDTH:0]    sum;
   logic [COUNT-1:0][ACC_WIDTH-1:0]  lane_nxt;
   logic [COUNT-1:0]                 lane_ovf;

   assign a_lanes = A_in;
   assign cnt_inc = cnt_q + TERMS_W'(1);

   // One guard bit: the top two bits of the sum disagree exactly on overflow.
   always_comb begin : lane_math
      sum      = '0;
      lane_nxt = '0;
      lane_ovf = '0;
      for (int i = 0; i < COUNT; i++) begin
         sum[i] = {acc_q[i][ACC_WIDTH-1], acc_q[i]}
                + {{(ACC_WIDTH+1-DATA_WIDTH){a_lanes[i][DATA_WIDTH-1]}},
                   a_lanes[i]};
         lane_ovf[i] = sum[i][ACC_WIDTH] ^ sum[i][ACC_WIDTH-1];
         if (lane_ovf[i] && (SATURATE != 0)) begin
            lane_nxt[i] = sum[i][ACC_WIDTH] ? MIN_V : MAX_V;
         end else begin
            lane_nxt[i] = sum[i][ACC_WIDTH-1:0];
         end
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      terms_d = terms_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = '0;
               cnt_d   = '0;
               terms_d = num_terms;
               state_d = (num_terms == '0) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d = lane_nxt;
               ovf_d = ovf_q | lane_ovf;
               cnt_d = cnt_inc;
               if (cnt_inc == terms_q) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= '0;
         cnt_q   <= '0;
         terms_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         terms_q <= terms_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign A_out     = acc_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_acc_array.sv
// Directed and randomized checks of mac_acc_array against an
// arithmetic reference model (true sums, then clamp or wrap).
module tb_mac_acc_array;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Main instance: 4 lanes, 16-bit data, 20-bit accumulators, saturating
   logic        m_start, m_iv, m_ir, m_ovl, m_or, m_busy;
   logic [7:0]  m_nt;
   logic [63:0] m_a;
   logic [79:0] m_out;
   logic [3:0]  m_ovf;

   mac_acc_array #(
      .DATA_WIDTH(16), .ACC_WIDTH(20), .COUNT(4),
      .TERMS_W(8), .SATURATE(1)
   ) dut_m (
      .clk(clk), .rst(rst), .start(m_start), .num_terms(m_nt),
      .in_valid(m_iv), .in_ready(m_ir), .A_in(m_a),
      .out_valid(m_ovl), .out_ready(m_or), .A_out(m_out),
      .overflow(m_ovf), .busy(m_busy)
   );

   // Pair of 8/8 two-lane instances sharing inputs: saturating and wrapping
   logic        p_start, p_iv, p_or;
   logic [7:0]  p_nt;
   logic [15:0] p_a;
   logic        s_ir, s_ovl, s_busy, w_ir, w_ovl, w_busy;
   logic [15:0] s_out, w_out;
   logic [1:0]  s_ovf, w_ovf;

   mac_acc_array #(
      .DATA_WIDTH(8), .ACC_WIDTH(8), .COUNT(2),
      .TERMS_W(8), .SATURATE(1)
   ) dut_s (
      .clk(clk), .rst(rst), .start(p_start), .num_terms(p_nt),
      .in_valid(p_iv), .in_ready(s_ir), .A_in(p_a),
      .out_valid(s_ovl), .out_ready(p_or), .A_out(s_out),
      .overflow(s_ovf), .busy(s_busy)
   );

   mac_acc_array #(
      .DATA_WIDTH(8), .ACC_WIDTH(8), .COUNT(2),
      .TERMS_W(8), .SATURATE(0)
   ) dut_w (
      .clk(clk), .rst(rst), .start(p_start), .num_terms(p_nt),
      .in_valid(p_iv), .in_ready(w_ir), .A_in(p_a),
      .out_valid(w_ovl), .out_ready(p_or), .A_out(w_out),
      .overflow(w_ovf), .busy(w_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: one beat added to a true sum, then clamped or wrapped
   function automatic longint upd(input longint acc, input longint a,
                                  input int w, input bit sat,
                                  output bit ov);
      longint mx, mn, s;
      mx = (64'sd1 <<< (w - 1)) - 1;
      mn = -(64'sd1 <<< (w - 1));
      s  = acc + a;
      ov = (s > mx) || (s < mn);
      if (!ov) return s;
      if (sat) return (s > mx) ? mx : mn;
      return (s > mx) ? s - (64'sd1 <<< w) : s + (64'sd1 <<< w);
   endfunction

   function automatic longint rnd16();
      logic signed [15:0] v;
      case ($urandom_range(3))
         0:       v = 16'sh7fff;
         1:       v = 16'sh8000;
         default: v = 16'($urandom);
      endcase
      return longint'(v);
   endfunction

   function automatic longint rnd8();
      logic signed [7:0] v;
      case ($urandom_range(3))
         0:       v = 8'sh7f;
         1:       v = 8'sh80;
         default: v = 8'($urandom);
      endcase
      return longint'(v);
   endfunction

   logic [79:0] m_exp;
   logic [3:0]  m_exp_ovf;

   task automatic run_main(input int n);
      longint acc [4];
      bit     ov;
      longint b;
      for (int i = 0; i < 4; i++) acc[i] = 0;
      m_exp_ovf = '0;
      m_start = 1'b1;
      m_nt    = 8'(n);
      step();
      m_start = 1'b0;
      chk("main_in_ready", 128'(m_ir), 128'(1));
      for (int k = 0; k < n; k++) begin
         while ($urandom_range(3) == 0) begin
            m_iv = 1'b0;
            m_a  = {$urandom, $urandom};
            step();
         end
         m_iv = 1'b1;
         for (int i = 0; i < 4; i++) begin
            b = rnd16();
            m_a[i*16 +: 16] = 16'(b);
            acc[i] = upd(acc[i], b, 20, 1'b1, ov);
            if (ov) m_exp_ovf[i] = 1'b1;
         end
         step();
      end
      m_iv = 1'b0;
      for (int i = 0; i < 4; i++) m_exp[i*20 +: 20] = 20'(acc[i]);
      chk("main_out_valid", 128'(m_ovl), 128'(1));
      chk("main_A_out", 128'(m_out), 128'(m_exp));
      chk("main_overflow", 128'(m_ovf), 128'(m_exp_ovf));
   endtask

   task automatic main_handshake();
      m_or = 1'b1;
      step();
      m_or = 1'b0;
      chk("main_idle_busy", 128'(m_busy), 128'(0));
      chk("main_idle_out_valid", 128'(m_ovl), 128'(0));
   endtask

   task automatic run_pair(input int n);
      longint as [2];
      longint aw [2];
      logic [15:0] es, ew;
      logic [1:0]  os, ow;
      bit ov;
      longint b;
      for (int i = 0; i < 2; i++) begin
         as[i] = 0;
         aw[i] = 0;
      end
      os = '0;
      ow = '0;
      p_start = 1'b1;
      p_nt    = 8'(n);
      step();
      p_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(2) == 0) begin
            p_iv = 1'b0;
            p_a  = 16'($urandom);
            step();
         end
         p_iv = 1'b1;
         for (int i = 0; i < 2; i++) begin
            b = rnd8();
            p_a[i*8 +: 8] = 8'(b);
            as[i] = upd(as[i], b, 8, 1'b1, ov);
            if (ov) os[i] = 1'b1;
            aw[i] = upd(aw[i], b, 8, 1'b0, ov);
            if (ov) ow[i] = 1'b1;
         end
         step();
      end
      p_iv = 1'b0;
      for (int i = 0; i < 2; i++) begin
         es[i*8 +: 8] = 8'(as[i]);
         ew[i*8 +: 8] = 8'(aw[i]);
      end
      chk("pair_sat_valid", 128'(s_ovl), 128'(1));
      chk("pair_sat_A_out", 128'(s_out), 128'(es));
      chk("pair_sat_overflow", 128'(s_ovf), 128'(os));
      chk("pair_wrap_A_out", 128'(w_out), 128'(ew));
      chk("pair_wrap_overflow", 128'(w_ovf), 128'(ow));
      p_or = 1'b1;
      step();
      p_or = 1'b0;
      chk("pair_idle_busy", 128'({s_busy, w_busy}), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      m_start = 0; m_iv = 0; m_or = 0; m_nt = 0; m_a = '0;
      p_start = 0; p_iv = 0; p_or = 0; p_nt = 0; p_a = '0;
      step();
      step();
      chk("rst_busy", 128'({m_busy, s_busy, w_busy}), 128'(0));
      chk("rst_in_ready", 128'({m_ir, s_ir, w_ir}), 128'(0));
      chk("rst_out_valid", 128'({m_ovl, s_ovl, w_ovl}), 128'(0));
      chk("rst_A_out", 128'({m_out, s_out, w_out}), 128'(0));
      chk("rst_overflow", 128'({m_ovf, s_ovf, w_ovf}), 128'(0));
      rst = 1'b0;
      step();

      // Three beats with gaps: lane0 5,-2,7 ; lane1 1,1,1
      p_start = 1'b1;
      p_nt    = 8'd3;
      step();
      p_start = 1'b0;
      chk("b3_in_ready", 128'(s_ir), 128'(1));
      p_iv = 1'b1; p_a = {8'sd1, 8'sd5};  step();
      p_iv = 1'b0; p_a = 16'hffff;        step();
      p_iv = 1'b1; p_a = {8'sd1, -8'sd2}; step();
      p_iv = 1'b0;                        step();
      chk("b3_running_sum", 128'(s_out), 128'(16'h0203));
      chk("b3_not_valid_yet", 128'(s_ovl), 128'(0));
      p_iv = 1'b1; p_a = {8'sd1, 8'sd7};  step();
      p_iv = 1'b0;
      chk("b3_out_valid", 128'(s_ovl), 128'(1));
      chk("b3_A_out", 128'(s_out), 128'(16'h030a));
      chk("b3_overflow", 128'(s_ovf), 128'(0));
      chk("b3_in_ready_hold", 128'(s_ir), 128'(0));
      p_or = 1'b1; step(); p_or = 1'b0;

      // Lane0 100+100: saturate to 127 vs wrap to -56; lane1 untouched
      p_start = 1'b1; p_nt = 8'd2; step(); p_start = 1'b0;
      p_iv = 1'b1; p_a = {8'd0, 8'd100};
      step();
      step();
      p_iv = 1'b0;
      chk("sat_A_out", 128'(s_out), 128'(16'h007f));
      chk("sat_overflow", 128'(s_ovf), 128'(2'b01));
      chk("wrap_A_out", 128'(w_out), 128'(16'h00c8));
      chk("wrap_overflow", 128'(w_ovf), 128'(2'b01));
      p_or = 1'b1; step(); p_or = 1'b0;

      // Random batch, then a long HOLD with start pulses
      run_main(6);
      for (int c = 0; c < 5; c++) begin
         m_start = c[0];
         m_nt    = 8'd3;
         step();
         chk("hold_out_valid", 128'(m_ovl), 128'(1));
         chk("hold_A_out", 128'(m_out), 128'(m_exp));
         chk("hold_overflow", 128'(m_ovf), 128'(m_exp_ovf));
         chk("hold_in_ready", 128'(m_ir), 128'(0));
      end
      m_start = 1'b1;
      m_or    = 1'b1;
      step();
      m_start = 1'b0;
      m_or    = 1'b0;
      chk("hs_start_ignored", 128'(m_busy), 128'(0));

      // Zero-term batch clears a non-zero result
      m_start = 1'b1; m_nt = 8'd0; step(); m_start = 1'b0;
      chk("zero_out_valid", 128'(m_ovl), 128'(1));
      chk("zero_in_ready", 128'(m_ir), 128'(0));
      chk("zero_A_out", 128'(m_out), 128'(0));
      chk("zero_overflow", 128'(m_ovf), 128'(0));
      main_handshake();

      // Reset mid-batch, with competing inputs asserted
      m_start = 1'b1; m_nt = 8'd4; step(); m_start = 1'b0;
      m_iv = 1'b1; m_a = {4{16'sh7fff}};
      step();
      step();
      chk("mid_running", 128'(m_out), 128'({4{20'h0fffe}}));
      rst = 1'b1; m_start = 1'b1; m_or = 1'b1;
      step();
      rst = 1'b0; m_start = 1'b0; m_or = 1'b0; m_iv = 1'b0;
      chk("mid_rst_busy", 128'(m_busy), 128'(0));
      chk("mid_rst_A_out", 128'(m_out), 128'(0));
      chk("mid_rst_flags", 128'({m_ir, m_ovl, m_ovf}), 128'(0));
      run_main(4);
      main_handshake();

      for (int t = 0; t < 15; t++) begin
         run_main(1 + $urandom_range(24));
         main_handshake();
      end
      for (int t = 0; t < 15; t++) begin
         run_pair(1 + $urandom_range(6));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
